// File: rtl/channel_fifo.sv
// channel_fifo
//   Synchronous FIFO implementing an ac_channel-style link between a producer
//   stage and a channel-consuming kernel. The producer pushes with
//   write_valid/write_ready. The consumer polls read_ready, pulses read_valid
//   for one cycle, and samples out_data on the following cycle.
//
//   Optional feature macro: CHANNEL_FIFO_FULL_PASS_EN
//     When this macro is defined, a full FIFO accepts a push in the same cycle
//     as a pop. The pushed word goes into the slot being freed. This adds a
//     combinational path from read_valid to write_ready.
//
// Parameters
//   WIDTH  data word width
//   DEPTH  entry count (power of two, >= 2)
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   in_data      word to push
//   write_valid  push request
//   write_ready  push can be accepted this cycle
//   read_valid   pop request
//   read_ready   at least one word stored
//   out_data     registered copy of the last popped word
//   count        occupancy, 0..DEPTH
module channel_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       write_valid,
  output logic                       write_ready,
  input  logic                       read_valid,
  output logic                       read_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push, pop;

  assign read_ready = (count != '0);
`ifdef CHANNEL_FIFO_FULL_PASS_EN
  // A pop frees a slot in the same cycle, so a full FIFO can still take a word.
  assign write_ready = (count != FULL) || read_valid;
`else
  assign write_ready = (count != FULL);
`endif

  assign push = write_valid && write_ready;
  assign pop  = read_valid && read_ready;

  // The storage array is never reset. Stale contents are unreachable because
  // the pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      out_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        out_data <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_channel_fifo.sv
// Directed self-checking bench for channel_fifo (WIDTH=32, DEPTH=4).
// Inputs change 1 time unit after a rising edge. Outputs are checked at the
// same point, so they reflect the state committed at that edge.
module tb_channel_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             write_valid;
  logic             write_ready;
  logic             read_valid;
  logic             read_ready;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       count;

  int n_cmp = 0;
  int n_err = 0;

  channel_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_data(in_data),
    .write_valid(write_valid), .write_ready(write_ready),
    .read_valid(read_valid), .read_ready(read_ready),
    .out_data(out_data), .count(count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int sum;
  int exp_cnt;

  initial begin
    rst = 1'b1; in_data = '0; write_valid = 1'b0; read_valid = 1'b0;
    // Reset then idle
    step(); step();
    rst = 1'b0;
    chk("rst_count", 32'(count), 0);
    chk("rst_rd_ready", 32'(read_ready), 0);
    chk("rst_wr_ready", 32'(write_ready), 1);
    chk("rst_out", out_data, 0);

    // First push becomes visible one cycle later
    write_valid = 1'b1; in_data = 32'd1;
    step();
    chk("push_vis_rd_ready", 32'(read_ready), 1);
    for (int i = 2; i <= 4; i++) begin
      in_data = 32'(i);
      step();
    end
    write_valid = 1'b0;
    chk("full_count", 32'(count), 4);
    chk("full_wr_ready", 32'(write_ready), 0);

`ifdef CHANNEL_FIFO_FULL_PASS_EN
    // A push together with a pop on a full FIFO: 99 is accepted
    write_valid = 1'b1; in_data = 32'd99; read_valid = 1'b1;
    #1 chk("pass_wr_ready", 32'(write_ready), 1);
    step();
    write_valid = 1'b0; read_valid = 1'b0;
    chk("pass_count", 32'(count), 4);
    chk("pass_out", out_data, 1);
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      read_valid = 1'b1; step(); read_valid = 1'b0;
      chk("pass_pop", out_data, (i == 3) ? 32'd99 : 32'(i + 2));
      sum += int'(out_data);
      step(); step();
    end
    chk("pass_sum", 32'(sum), 108);
`else
    // A push on a full FIFO without a pop: 99 is dropped
    write_valid = 1'b1; in_data = 32'd99;
    #1 chk("drop_wr_ready", 32'(write_ready), 0);
    step();
    write_valid = 1'b0;
    chk("drop_count", 32'(count), 4);
    sum = 0;
    for (int i = 1; i <= 4; i++) begin
      read_valid = 1'b1; step(); read_valid = 1'b0;
      chk("pop_out", out_data, 32'(i));
      sum += int'(out_data);
      step(); step();
      chk("pop_hold", out_data, 32'(i));
    end
    chk("reduce_sum", 32'(sum), 10);
`endif
    chk("drained_count", 32'(count), 0);
    chk("drained_rd_ready", 32'(read_ready), 0);

    // A pop on an empty FIFO is ignored
    read_valid = 1'b1; step(); read_valid = 1'b0;
`ifdef CHANNEL_FIFO_FULL_PASS_EN
    chk("empty_pop_out", out_data, 99);
`else
    chk("empty_pop_out", out_data, 4);
`endif
    chk("empty_pop_count", 32'(count), 0);

    // A push and a pop on an empty FIFO: the push wins and the pop is ignored
    write_valid = 1'b1; read_valid = 1'b1; in_data = 32'd55;
    step();
    write_valid = 1'b0; read_valid = 1'b0;
    chk("pp_empty_count", 32'(count), 1);
    read_valid = 1'b1; step(); read_valid = 1'b0;
    chk("pp_empty_out", out_data, 55);
    chk("pp_empty_count2", 32'(count), 0);

    // Wrap-around: 10 words, occupancy held at 1..2
    write_valid = 1'b1;
    in_data = 32'hA0; step();
    chk("wrap_cnt0", 32'(count), 1);
    in_data = 32'hA1; step();
    chk("wrap_cnt1", 32'(count), 2);
    read_valid = 1'b1;
    for (int i = 2; i < 10; i++) begin
      in_data = 32'hA0 + 32'(i);
      step();
      chk("wrap_out", out_data, 32'hA0 + 32'(i - 2));
      chk("wrap_cnt", 32'(count), 2);
    end
    write_valid = 1'b0;
    exp_cnt = 2;
    for (int i = 8; i < 10; i++) begin
      step();
      exp_cnt--;
      chk("wrap_tail_out", out_data, 32'hA0 + 32'(i));
      chk("wrap_tail_cnt", 32'(count), 32'(exp_cnt));
    end
    read_valid = 1'b0;

    // Reset mid-operation with count=3. A push in the reset cycle is ignored.
    write_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin in_data = 32'(i); step(); end
    chk("pre_rst_count", 32'(count), 3);
    rst = 1'b1; in_data = 32'h77; step();
    rst = 1'b0; write_valid = 1'b0;
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_rd_ready", 32'(read_ready), 0);
    chk("mid_rst_out", out_data, 0);
    write_valid = 1'b1; in_data = 32'd7; step(); write_valid = 1'b0;
    read_valid = 1'b1; step(); read_valid = 1'b0;
    chk("post_rst_out", out_data, 7);
    chk("post_rst_count", 32'(count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
